// File: rtl/mipi_csi_raw_depacker.sv
// mipi_csi_raw_depacker: unpacks CSI-2 RAW10/12/14 payload words into groups of 4 MSB-aligned 14-bit pixels.
// Ports: clk_i, reset_i (sync, active-high); data_valid_i/data_i/packet_type_i payload in;
// output_valid_o/output_o (P0 in [13:0] .. P3 in [55:42]); packet_end_o and residue_error_o pulse after a packet.
module mipi_csi_raw_depacker #(
    parameter int LANES      = 4,
    parameter int PIXEL_SLOT = 14
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      data_valid_i,
    input  logic [8*LANES-1:0]        data_i,
    input  logic [2:0]                packet_type_i,
    output logic                      output_valid_o,
    output logic [4*PIXEL_SLOT-1:0]   output_o,
    output logic                      packet_end_o,
    output logic                      residue_error_o
);
    localparam logic [2:0] T10 = 3'd3;
    localparam logic [2:0] T12 = 3'd4;
    localparam logic [2:0] T14 = 3'd5;
    logic armed, active;
    logic [2:0] ptype;
    logic [79:0] buf_q;
    logic [3:0] cnt;
    logic take, emit;
    logic [2:0] cur_type;
    logic [3:0] g, c, n;
    logic [79:0] merged, rem;
    logic [7:0] b [7];
    logic [55:0] p10, p12, p14, pix;
    // The first word of a packet uses the live type and an empty buffer.
    assign take     = armed && data_valid_i;
    assign cur_type = active ? ptype : packet_type_i;
    assign g        = cur_type == T10 ? 4'd5 : cur_type == T12 ? 4'd6 : cur_type == T14 ? 4'd7 : 4'd0;
    assign c        = active ? cnt : 4'd0;
    assign n        = c + 4'd4;
    assign merged   = (active ? buf_q : 80'd0) | ({{(80-8*LANES){1'b0}}, data_i} << {c, 3'b0});
    assign rem      = merged >> {g, 3'b0};
    assign emit     = take && g != 4'd0 && n >= g;
    always_comb begin
        for (int k = 0; k < 7; k++) b[k] = merged[8*k +: 8];
        p10 = {b[3], b[4][7:6], 4'b0, b[2], b[4][5:4], 4'b0, b[1], b[4][3:2], 4'b0, b[0], b[4][1:0], 4'b0};
        p12 = {b[4], b[5][7:4], 2'b0, b[3], b[5][3:0], 2'b0, b[1], b[2][7:4], 2'b0, b[0], b[2][3:0], 2'b0};
        p14 = {b[3], b[6][7:2], b[2], b[6][1:0], b[5][7:4], b[1], b[5][3:0], b[4][7:6], b[0], b[4][5:0]};
        pix = cur_type == T10 ? p10 : cur_type == T12 ? p12 : p14;
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            armed           <= 1'b0;
            active          <= 1'b0;
            ptype           <= 3'd0;
            buf_q           <= 80'd0;
            cnt             <= 4'd0;
            output_valid_o  <= 1'b0;
            output_o        <= '0;
            packet_end_o    <= 1'b0;
            residue_error_o <= 1'b0;
        end else begin
            armed           <= armed | ~data_valid_i;
            output_valid_o  <= emit;
            packet_end_o    <= active && !data_valid_i;
            residue_error_o <= active && !data_valid_i && cnt != 4'd0;
            if (emit) output_o <= pix;
            if (take) begin
                active <= 1'b1;
                ptype  <= cur_type;
                // Unsupported types never accumulate, so they end with no residue.
                buf_q  <= g == 4'd0 ? 80'd0 : emit ? rem : merged;
                cnt    <= g == 4'd0 ? 4'd0 : emit ? n - g : n;
            end else begin
                active <= 1'b0;
                ptype  <= 3'd0;
                buf_q  <= 80'd0;
                cnt    <= 4'd0;
            end
        end
    end
endmodule

// File: tb/tb_mipi_csi_raw_depacker.sv
// tb_mipi_csi_raw_depacker: scoreboard bench for the RAW10/12/14 depacker.
module tb_mipi_csi_raw_depacker;
    logic clk_i = 1'b0;
    logic reset_i, data_valid_i;
    logic [31:0] data_i;
    logic [2:0] packet_type_i;
    logic output_valid_o, packet_end_o, residue_error_o;
    logic [55:0] output_o;

    mipi_csi_raw_depacker dut (
        .clk_i(clk_i), .reset_i(reset_i), .data_valid_i(data_valid_i), .data_i(data_i),
        .packet_type_i(packet_type_i), .output_valid_o(output_valid_o), .output_o(output_o),
        .packet_end_o(packet_end_o), .residue_error_o(residue_error_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0, fails = 0;
    logic [7:0] mq[$];
    logic [55:0] sb[$];
    int mtype;
    bit in_pkt = 0;
    logic [6:0] pat;
    int widx;
    logic [55:0] last_out;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [55:0] model(input int t, input logic [55:0] gb);
        int bt[7];
        int p[4];
        int lsb, sh;
        logic [55:0] r;
        for (int k = 0; k < 7; k++) bt[k] = int'(gb[8*k +: 8]);
        lsb = bt[4] | (bt[5] << 8) | (bt[6] << 16);
        sh = 0;
        for (int i = 0; i < 4; i++) begin
            if (t == 3) begin
                p[i] = (bt[i] << 2) | ((bt[4] >> (2*i)) & 3);
                sh = 4;
            end else if (t == 4) begin
                p[i] = (bt[(i/2)*3 + i%2] << 4) | ((bt[(i/2)*3 + 2] >> (4*(i%2))) & 15);
                sh = 2;
            end else
                p[i] = (bt[i] << 6) | ((lsb >> (6*i)) & 63);
        end
        r = '0;
        for (int i = 0; i < 4; i++) r = r | (56'(p[i] << sh) << (14*i));
        return r;
    endfunction

    task automatic send(input logic [31:0] w, input logic [2:0] t);
        int g;
        logic exp_v;
        logic [55:0] gb;
        if (!in_pkt) begin
            in_pkt = 1;
            mtype = int'(t);
        end
        g = mtype == 3 ? 5 : mtype == 4 ? 6 : mtype == 5 ? 7 : 0;
        exp_v = 0;
        if (g != 0) begin
            for (int k = 0; k < 4; k++) mq.push_back(w[8*k +: 8]);
            if (mq.size() >= g) begin
                gb = '0;
                for (int k = 0; k < g; k++) gb[8*k +: 8] = mq.pop_front();
                sb.push_back(model(mtype, gb));
                exp_v = 1;
            end
        end
        data_valid_i = 1;
        data_i = w;
        packet_type_i = t;
        @(posedge clk_i);
        #1;
        check("valid", output_valid_o, exp_v);
        pat[widx] = output_valid_o;
        widx++;
        if (output_valid_o) begin
            if (sb.size() == 0) check("sb_count", 64'(sb.size()), 1);
            else check("pixels", output_o, sb.pop_front());
            last_out = output_o;
        end
    endtask

    task automatic end_pkt();
        logic exp_r;
        exp_r = mq.size() != 0;
        data_valid_i = 0;
        @(posedge clk_i);
        #1;
        check("pkt_end", packet_end_o, 1);
        check("residue", residue_error_o, exp_r);
        check("valid_at_end", output_valid_o, 0);
        check("sb_drain", 64'(sb.size()), 0);
        mq.delete();
        sb.delete();
        in_pkt = 0;
    endtask

    task automatic idle();
        data_valid_i = 0;
        @(posedge clk_i);
        #1;
        check("idle_end", packet_end_o, 0);
        check("idle_valid", output_valid_o, 0);
    endtask

    task automatic new_test();
        pat = '0;
        widx = 0;
    endtask

    logic [31:0] w12[3] = '{32'h1221CDAB, 32'hCDAB6534, 32'h65341221};

    initial begin
        reset_i = 1;
        data_valid_i = 0;
        data_i = '0;
        packet_type_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid", output_valid_o, 0);
        check("rst_out", output_o, 0);
        check("rst_end", packet_end_o, 0);
        check("rst_residue", residue_error_o, 0);
        reset_i = 0;
        idle();

        // RAW10 single group padded to 5 words
        new_test();
        send(32'h04030201, 3'd3);
        send(32'h000000E4, 3'd3);
        check("raw10_first", last_out, {14'h130, 14'h0E0, 14'h090, 14'h040});
        for (int i = 0; i < 3; i++) send(32'h0, 3'd3);
        check("raw10_pattern", 64'(pat[4:0]), 5'b11110);
        end_pkt();
        check("raw10_no_residue", residue_error_o, 0);
        idle();

        // RAW12 repeating pair pattern
        new_test();
        for (int i = 0; i < 3; i++) send(w12[i], 3'd4);
        check("raw12_pix", last_out, {14'(12'h346) << 2, 14'(12'h125) << 2, 14'(12'hCD2) << 2, 14'(12'hAB1) << 2});
        check("raw12_pattern", 64'(pat[2:0]), 3'b110);
        end_pkt();

        // RAW14 incrementing bytes
        new_test();
        for (int i = 0; i < 7; i++) begin
            send({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 3'd5);
            if (i == 1) check("raw14_p0", 64'(last_out[13:0]), 14'h0004);
        end
        check("raw14_pattern", 64'(pat), 7'b1101010);
        end_pkt();

        // RAW10 truncated packet leaves 2 residue bytes
        new_test();
        send(32'hA5A55A5A, 3'd3);
        send(32'h12345678, 3'd3);
        send(32'hDEADBEEF, 3'd3);
        check("res_pattern", 64'(pat[2:0]), 3'b110);
        end_pkt();
        check("res_flag", residue_error_o, 1);
        new_test();
        send(32'h04030201, 3'd3);
        send(32'h000000E4, 3'd3);
        check("res_clean_next", last_out, {14'h130, 14'h0E0, 14'h090, 14'h040});
        for (int i = 0; i < 3; i++) send(32'hFFFFFFFF, 3'd3);
        end_pkt();

        // Reset in the middle of a RAW12 packet
        new_test();
        send(w12[0], 3'd4);
        reset_i = 1;
        data_i = w12[1];
        @(posedge clk_i);
        #1;
        check("mid_rst_valid", output_valid_o, 0);
        check("mid_rst_out", output_o, 0);
        check("mid_rst_end", packet_end_o, 0);
        check("mid_rst_residue", residue_error_o, 0);
        reset_i = 0;
        data_i = w12[2];
        @(posedge clk_i);
        #1;
        check("mid_rst_ignored", output_valid_o, 0);
        mq.delete();
        sb.delete();
        in_pkt = 0;
        idle();
        new_test();
        for (int i = 0; i < 3; i++) send(w12[i], 3'd4);
        check("post_rst_pattern", 64'(pat[2:0]), 3'b110);
        end_pkt();

        // Unsupported packet type
        new_test();
        for (int i = 0; i < 4; i++) send(32'h11223344 + 32'(i), 3'd6);
        check("unsup_pattern", 64'(pat[3:0]), 4'b0000);
        end_pkt();
        check("unsup_residue", residue_error_o, 0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mipi_csi_raw_depacker.md
Name: mipi_csi_raw_depacker

Overview:
Sits directly downstream of the CSI packet decoder. It takes stripped 32-bit payload words and the latched packet type (RAW10/RAW12/RAW14), and unpacks the CSI-2 byte stream into groups of 4 pixels. Output pixels are MSB-aligned in 14-bit slots, so later stages (debayer/output formatter) handle all bit depths uniformly. Residue bytes are carried across input words through a byte-shift buffer.

Parameters:
LANES, 4, bytes per input word; fixed at 4, other values unsupported.
PIXEL_SLOT, 14, output bits per pixel slot.

Ports:
clk_i  input  1  byte clock; all logic on rising edge.
reset_i  input  1  synchronous, active-high reset.
data_valid_i  input  1  payload word valid; high for the whole packet payload, low between packets.
data_i  input  32  payload word; data_i[7:0] is the first byte on the wire, [31:24] the last.
packet_type_i  input  3  3=RAW10, 4=RAW12, 5=RAW14; sampled on the first valid word only.
output_valid_o  output  1  output_o holds 4 valid pixels this cycle.
output_o  output  56  pixels; P0=[13:0], P1=[27:14], P2=[41:28], P3=[55:42]; value left-justified in its slot, LSBs zero.
packet_end_o  output  1  one-cycle pulse on the cycle after data_valid_i falls, if a packet was active.
residue_error_o  output  1  one-cycle pulse with packet_end_o when leftover bytes were non-zero at packet end.

Behaviour:
- Reset: all outputs 0, byte count 0, buffer 0, type cleared, armed=0. Synchronous reset has priority over all inputs.
- Arming: after reset, input is ignored until data_valid_i has been sampled low at least once (armed=1). A packet cut by reset is never resumed mid-stream.
- Packet start: first rising edge with data_valid_i=1 while idle latches packet_type_i. The group size G is 5 bytes for RAW10, 6 for RAW12, 7 for RAW14.
- Unsupported type (not 3/4/5): the whole packet is dropped. No output_valid_o, no residue_error_o; packet_end_o still pulses.
- Buffer: 10 bytes, oldest byte first, with count C (0..9). On each valid word, the 4 bytes are appended at position C, and the new count is N=C+4.
  - If N>=G: emit the oldest G bytes as 4 pixels, shift the remainder down, and set C=N-G.
  - Otherwise: C=N, no output.
  - Invariant: C<G after every cycle, so at most one group is emitted per cycle.
- Latency: output_o/output_valid_o are registered and appear on the rising edge that samples the completing word (1-cycle latency). output_valid_o is 0 on all other cycles, and output_o holds its last value.
- RAW10 unpack (bytes B0..B4):
  - Px[9:2]=Bx.
  - B4 LSB fields: [1:0]=P0, [3:2]=P1, [5:4]=P2, [7:6]=P3.
  - Slot = {P,4'b0}.
- RAW12 unpack (B0..B5, two 3-byte pairs):
  - P0[11:4]=B0, P1[11:4]=B1, B2[3:0]=P0[3:0], B2[7:4]=P1[3:0].
  - P2/P3 use B3..B5 the same way.
  - Slot = {P,2'b0}.
- RAW14 unpack (B0..B6):
  - Px[13:6]=Bx.
  - B4[5:0]=P0[5:0]; B4[7:6]=P1[1:0]; B5[3:0]=P1[5:2]; B5[7:4]=P2[3:0]; B6[1:0]=P2[5:4]; B6[7:2]=P3[5:0].
  - Slot = P.
- Emission pattern from packet start (1=emit):
  - RAW10: 0,1,1,1,1 repeating per 5 words.
  - RAW12: 0,1,1 per 3 words.
  - RAW14: 0,1,0,1,0,1,1 per 7 words.
- Packet end: on the first cycle data_valid_i=0 after an active packet:
  - packet_end_o=1.
  - residue_error_o=(C!=0).
  - Leftover bytes discarded; C and type cleared.
- Back-to-back packets need at least one low cycle of data_valid_i between them (the decoder guarantees this). A type change without a low cycle is ignored.
- A gap in data_valid_i always ends the packet; no pause/resume.

Test Plan:
- RAW10, one group then pad: words 0x04030201, 0x000000E4 (pad to 5 words). Required: first output on word 2 with P0..P3=0x004,0x009,0x00E,0x013; slots 0x040,0x090,0x0E0,0x130; valid pattern 0,1,1,1,1; no residue_error_o.
- RAW12: 3 words of bytes 0xAB,0xCD,0x21,0x12,0x34,0x65 repeated. Required: P0=0xAB1, P1=0xCD2, P2=0x125, P3=0x346 (slots <<2); valid 0,1,1.
- RAW14: 7 words of incrementing bytes 0x00..0x1B. Required: valid pattern 0,1,0,1,0,1,1; first group's P0={0x00,B4[5:0]=0x04} equals 0x0004.
- Residue: RAW10, 3 words then data_valid_i low. Required: two groups emitted, then packet_end_o=1 and residue_error_o=1 (C=2) on the next cycle; the next packet starts clean.
- Reset mid-packet: assert reset_i during word 2 of a RAW12 packet with data_valid_i held high. Required: all outputs 0, no output for the remaining words; a following packet (after a low cycle) decodes correctly.
- Unsupported type 0x6 for 4 words. Required: output_valid_o never 1, packet_end_o pulses, residue_error_o=0.
